// File: rtl/regs_link_rx_pkg.sv
// Shared types for the credit-flowed registered link receiver.
// FSM state encodings used by regs_link_rx.
package regs_link_rx_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/regs_link_rx_fifo.sv
// FWFT buffer for regs_link_rx: storage, pointers, count.
// Head word is read straight from the registered array.
module regs_link_rx_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             rd;
    logic             wr;

    // A pop frees its slot in the same cycle, so a full buffer may still accept
    assign rd    = rd_en & ~empty;
    assign wr    = wr_en & (~full | rd);
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = mem[rd_ptr];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule

// File: rtl/regs_link_rx.sv
// Receive end of a registered credit-flowed link; FWFT output buffer.
// Optional parity check on incoming words: define LINK_RX_PARITY_EN.
module regs_link_rx #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             link_valid,
    input  logic [WIDTH-1:0] link_data,
    input  logic             link_par,
    output logic             link_credit,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_rd,
    output logic             err
);

    import regs_link_rx_pkg::*;

    localparam int AW = $clog2(DEPTH);

    state_t        state;
    state_t        state_d;
    logic [AW-1:0] init_cnt;
    logic [AW-1:0] init_cnt_d;
    logic          credit_q;
    logic          credit_d;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovf;
    logic          par_bad;
    logic          fault;

`ifdef LINK_RX_PARITY_EN
    assign par_bad = link_valid & ((^link_data) ^ link_par);
`else
    logic unused_par;
    assign unused_par = link_par;
    assign par_bad    = 1'b0;
`endif

    assign pop   = ~empty & out_rd;
    assign ovf   = link_valid & full & ~pop;
    assign fault = ovf | par_bad;
    assign push  = link_valid & ~fault & (state != S_ERR);

    regs_link_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .rst_n (rst_n),
        .wr_en (push),
        .din   (link_data),
        .rd_en (pop),
        .dout  (out_data),
        .empty (empty),
        .full  (full)
    );

    assign out_valid   = ~empty;
    assign link_credit = credit_q;
    assign err         = (state == S_ERR);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
            credit_q <= 1'b0;
        end else begin
            state    <= state_d;
            init_cnt <= init_cnt_d;
            credit_q <= credit_d;
        end
    end

    always_comb begin
        state_d    = state;
        init_cnt_d = init_cnt;
        credit_d   = 1'b0;
        unique case (state)
            S_INIT: begin
                credit_d   = 1'b1;
                init_cnt_d = init_cnt + AW'(1);
                if (init_cnt == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                credit_d = pop;
            end
            S_ERR: begin
                credit_d = 1'b0;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
        // An error stops credit return for good, even mid-init
        if (fault) begin
            state_d  = S_ERR;
            credit_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_regs_link_rx.sv
// Testbench for regs_link_rx: vector table plus scoreboard-checked sequences.
module tb_regs_link_rx;

    localparam int W = 64;
    localparam int D = 8;

    logic         CLK = 1'b0;
    logic         rst_n = 1'b0;
    logic         link_valid = 1'b0;
    logic [W-1:0] link_data = '0;
    logic         link_par = 1'b0;
    logic         out_rd = 1'b0;
    logic         link_credit;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         err;

    always #5 CLK = ~CLK;

    regs_link_rx #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .link_valid  (link_valid),
        .link_data   (link_data),
        .link_par    (link_par),
        .link_credit (link_credit),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .err         (err)
    );

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           rd;
        bit           eov;
        logic [W-1:0] edat;
        bit           ecr;
    } vec_t;

    vec_t         tbl [10];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] q [$];
    int           mcnt;
    int           minit;
    bit           merr;
    bit           ecr;

    function automatic bit par(input logic [W-1:0] d);
        return ^d;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mcnt  = 0;
        minit = 0;
        merr  = 1'b0;
        ecr   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        link_valid = 1'b0;
        out_rd = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_credit", W'(link_credit), '0);
        chk("rst_err", W'(err), '0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive, check at negedge against the model, update model
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit p,
                       input bit rd, output bit cr, output bit ov,
                       output logic [W-1:0] dat);
        bit popped;
        bit bad_par;
        link_valid = v;
        link_data  = d;
        link_par   = p;
        out_rd     = rd;
        @(negedge CLK);
        chk("out_valid", W'(out_valid), W'(mcnt != 0));
        if (mcnt != 0) chk("out_data", out_data, q[0]);
        chk("link_credit", W'(link_credit), W'(ecr));
        chk("err", W'(err), W'(merr));
        cr  = link_credit;
        ov  = out_valid;
        dat = out_data;
`ifdef LINK_RX_PARITY_EN
        bad_par = v && ((^d) != p);
`else
        bad_par = 1'b0;
`endif
        popped = (mcnt != 0) && rd;
        if (popped) begin
            void'(q.pop_front());
            mcnt--;
        end
        if (v && !merr) begin
            if (bad_par || mcnt >= D) begin
                merr = 1'b1;
            end else begin
                q.push_back(d);
                mcnt++;
            end
        end
        if (merr) ecr = 1'b0;
        else if (minit < D) begin
            ecr = 1'b1;
            minit++;
        end else ecr = popped;
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit rd,
                        output bit cr);
        bit           ov;
        logic [W-1:0] dat;
        cyc(v, d, par(d), rd, cr, ov, dat);
    endtask

    task automatic idle(input int n, input bit rd, output int crs);
        bit c;
        crs = 0;
        repeat (n) begin
            step(1'b0, '0, rd, c);
            crs += int'(c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit           c;
        bit           ov;
        logic [W-1:0] dat;
        int           n;

        tbl[0] = '{1'b1, 64'h11, 1'b1, 1'b0, 64'h0,  1'b0};
        tbl[1] = '{1'b1, 64'h22, 1'b1, 1'b1, 64'h11, 1'b0};
        tbl[2] = '{1'b1, 64'h33, 1'b1, 1'b1, 64'h22, 1'b1};
        tbl[3] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h33, 1'b1};
        tbl[4] = '{1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b1};
        tbl[5] = '{1'b1, 64'h44, 1'b0, 1'b0, 64'h0,  1'b0};
        tbl[6] = '{1'b1, 64'h55, 1'b0, 1'b1, 64'h44, 1'b0};
        tbl[7] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h44, 1'b0};
        tbl[8] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h55, 1'b1};
        tbl[9] = '{1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  1'b1};

        // Init credits after reset release
        do_reset();
        idle(12, 1'b0, n);
        chk("init_credits", W'(n), W'(8));

        // Vector table: streaming push/pop
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].d, par(tbl[i].d), tbl[i].rd, c, ov, dat);
            chk("tbl_ov", W'(ov), W'(tbl[i].eov));
            if (tbl[i].eov) chk("tbl_data", dat, tbl[i].edat);
            chk("tbl_credit", W'(c), W'(tbl[i].ecr));
        end
        idle(2, 1'b0, n);

        // Full buffer, push with simultaneous pop
        for (int i = 0; i < 8; i++) step(1'b1, 64'hA0 + 64'(i), 1'b0, c);
        step(1'b1, 64'hA8, 1'b1, c);
        idle(3, 1'b0, n);
        chk("full_pop_credit", W'(n), W'(1));
        chk("full_pop_err", W'(err), '0);
        idle(10, 1'b1, n);
        chk("full_pop_drained", W'(out_valid), '0);

        // Overflow: error, drop, no credits, drain in order
        do_reset();
        idle(12, 1'b0, n);
        for (int i = 0; i < 8; i++) step(1'b1, 64'hB0 + 64'(i), 1'b0, c);
        step(1'b1, 64'hB8, 1'b0, c);
        chk("ovf_err", W'(err), W'(1));
        idle(10, 1'b1, n);
        chk("ovf_credits", W'(n), '0);
        chk("ovf_drained", W'(out_valid), '0);
        chk("ovf_sticky", W'(err), W'(1));

        // Reset with words buffered
        do_reset();
        idle(12, 1'b0, n);
        for (int i = 0; i < 5; i++) step(1'b1, 64'hC0 + 64'(i), 1'b0, c);
        chk("pre_rst_valid", W'(out_valid), W'(1));
        do_reset();
        idle(12, 1'b0, n);
        chk("re_init_credits", W'(n), W'(8));

        // Parity: 0x1 with link_par=0
        cyc(1'b1, 64'h1, 1'b0, 1'b0, c, ov, dat);
        idle(1, 1'b0, n);
`ifdef LINK_RX_PARITY_EN
        chk("par_err", W'(err), W'(1));
        chk("par_dropped", W'(out_valid), '0);
`else
        chk("par_err", W'(err), '0);
        chk("par_accepted", W'(out_valid), W'(1));
`endif
        idle(3, 1'b1, n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
